// File: rtl/noc_params.sv
// Shared NoC link types: flit layout, flit labels and address/data widths.
// No logic; widths here fix the router2router flit format.
// Consumers import with noc_params::*.
package noc_params;

    localparam int VC_NUM           = 2;
    localparam int VC_SIZE          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int FLIT_DATA_SIZE   = 32;
    localparam int HEAD_PL_SIZE     = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [HEAD_PL_SIZE-1:0]     head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

endpackage

// File: rtl/node_injector_pkg.sv
// Injector-local types: control FSM state encoding.
// State literals carry an ST_ prefix so they never clash with flit labels.
// Imported alongside noc_params by the injector and its bench.
package node_injector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALLOC,
        ST_HEAD,
        ST_BODY
    } injector_state_t;

endpackage

// File: rtl/node_injector_rr_vc_arbiter.sv
// Round-robin VC arbiter: one-hot grant to the first request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is raised.
module rr_vc_arbiter #(
    parameter int VC_NUM = 2,
    localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic [VC_NUM-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [VC_NUM-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(ptr) + i) % VC_NUM;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/node_injector.sv
// Node-side injector: turns descriptors + payload words into flits on one router local port.
// Latency: head flit visible 3 cycles after descriptor handshake, then up to one flit per cycle.
// Backpressure: per-flit gating by on_off_i of the held VC; payload consumed only when a body/tail goes out.
module node_injector
    import noc_params::*;
    import node_injector_pkg::*;
#(
    parameter int VC_NUM          = 2,
    parameter int PKT_LEN_W       = 8,
    parameter int REALLOC_HOLDOFF = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i,
    input  logic [PKT_LEN_W-1:0]        pkt_len_i,
    input  logic                        payload_valid_i,
    input  logic [FLIT_DATA_SIZE-1:0]   payload_i,
    output logic                        payload_ready_o,
    output flit_t                       data_o,
    output logic                        valid_flit_o,
    input  logic [VC_NUM-1:0]           on_off_i,
    input  logic [VC_NUM-1:0]           is_allocatable_i,
    output logic                        busy_o
);

    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int HOLD_W = $clog2(REALLOC_HOLDOFF + 1);

    injector_state_t             state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0] dest_x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] dest_y_q;
    logic [PKT_LEN_W-1:0]        remaining_q;
    logic [VC_W-1:0]             vc_q;
    logic [VC_W-1:0]             rr_ptr_q;
    logic [HOLD_W-1:0]           holdoff_q [VC_NUM];

    logic [VC_NUM-1:0] eligible;
    logic [VC_NUM-1:0] grant;
    logic [VC_W-1:0]   grant_idx;
    logic              vc_on;
    logic              emit;
    flit_t             flit_d;
    logic              latch_pkt;
    logic              latch_vc;
    logic              dec_rem;
    logic              load_holdoff;

    // A VC that just carried a tail stays off-limits until the router has drained it.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            eligible[v] = is_allocatable_i[v] && (holdoff_q[v] == '0);
        end
    end

    rr_vc_arbiter #(
        .VC_NUM (VC_NUM)
    ) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (grant[i]) grant_idx = VC_W'(i);
        end
    end

    assign vc_on  = on_off_i[vc_q];
    assign busy_o = (state_q != ST_IDLE);

    always_comb begin
        state_d         = state_q;
        emit            = 1'b0;
        flit_d          = '0;
        latch_pkt       = 1'b0;
        latch_vc        = 1'b0;
        dec_rem         = 1'b0;
        load_holdoff    = 1'b0;
        pkt_ready_o     = 1'b0;
        payload_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    latch_pkt = 1'b1;
                    state_d   = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (|grant) begin
                    latch_vc = 1'b1;
                    state_d  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (vc_on) begin
                    emit                          = 1'b1;
                    flit_d.flit_label             = (remaining_q == '0) ? HEADTAIL : HEAD;
                    flit_d.vc_id                  = VC_SIZE'(vc_q);
                    flit_d.data.head_data.x_dest  = dest_x_q;
                    flit_d.data.head_data.y_dest  = dest_y_q;
                    if (remaining_q == '0) begin
                        load_holdoff = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d      = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                payload_ready_o = vc_on && payload_valid_i;
                if (payload_ready_o) begin
                    emit              = 1'b1;
                    dec_rem           = 1'b1;
                    flit_d.flit_label = (remaining_q == PKT_LEN_W'(1)) ? TAIL : BODY;
                    flit_d.vc_id      = VC_SIZE'(vc_q);
                    flit_d.data.bt_pl = payload_i;
                    if (remaining_q == PKT_LEN_W'(1)) begin
                        load_holdoff = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing handshakes while reset is being applied.
        if (rst) begin
            pkt_ready_o     = 1'b0;
            payload_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_flit_o <= 1'b0;
            data_o       <= '0;
            dest_x_q     <= '0;
            dest_y_q     <= '0;
            remaining_q  <= '0;
            vc_q         <= '0;
            rr_ptr_q     <= '0;
            for (int v = 0; v < VC_NUM; v++) holdoff_q[v] <= '0;
        end else begin
            state_q      <= state_d;
            valid_flit_o <= emit;
            if (emit) data_o <= flit_d;

            if (latch_pkt) begin
                dest_x_q    <= pkt_dest_x_i;
                dest_y_q    <= pkt_dest_y_i;
                remaining_q <= (pkt_len_i == '0) ? '0 : pkt_len_i - PKT_LEN_W'(1);
            end else if (dec_rem) begin
                remaining_q <= remaining_q - PKT_LEN_W'(1);
            end

            if (latch_vc) begin
                vc_q     <= grant_idx;
                rr_ptr_q <= (grant_idx == VC_W'(VC_NUM - 1)) ? '0 : grant_idx + VC_W'(1);
            end

            for (int v = 0; v < VC_NUM; v++) begin
                if (load_holdoff && (vc_q == VC_W'(v)))
                    holdoff_q[v] <= HOLD_W'(REALLOC_HOLDOFF);
                else if (holdoff_q[v] != '0)
                    holdoff_q[v] <= holdoff_q[v] - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: reset, latency, on_off stalls, VC round-robin,
// reallocation holdoff, allocation stall and mid-packet reset.
// Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
module tb_node_injector;
    import noc_params::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        pkt_valid_i;
    logic                        pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i;
    logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i;
    logic [7:0]                  pkt_len_i;
    logic                        payload_valid_i;
    logic [FLIT_DATA_SIZE-1:0]   payload_i;
    logic                        payload_ready_o;
    flit_t                       data_o;
    logic                        valid_flit_o;
    logic [1:0]                  on_off_i;
    logic [1:0]                  is_allocatable_i;
    logic                        busy_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    node_injector #(
        .VC_NUM          (2),
        .PKT_LEN_W       (8),
        .REALLOC_HOLDOFF (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .pkt_dest_x_i     (pkt_dest_x_i),
        .pkt_dest_y_i     (pkt_dest_y_i),
        .pkt_len_i        (pkt_len_i),
        .payload_valid_i  (payload_valid_i),
        .payload_i        (payload_i),
        .payload_ready_o  (payload_ready_o),
        .data_o           (data_o),
        .valid_flit_o     (valid_flit_o),
        .on_off_i         (on_off_i),
        .is_allocatable_i (is_allocatable_i),
        .busy_o           (busy_o)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_flit(input string tag, input flit_label_t lbl,
                            input logic [VC_SIZE-1:0] vc, input logic [31:0] dat);
        chk({tag, ".valid"}, 32'(valid_flit_o), 32'd1);
        chk({tag, ".label"}, 32'(data_o.flit_label), 32'(lbl));
        chk({tag, ".vc"},    32'(data_o.vc_id), 32'(vc));
        chk({tag, ".data"},  data_o.data.bt_pl, dat);
    endtask

    task automatic do_reset;
        rst             = 1'b1;
        pkt_valid_i     = 1'b0;
        payload_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        pkt_valid_i      = 1'b0;
        pkt_dest_x_i     = '0;
        pkt_dest_y_i     = '0;
        pkt_len_i        = '0;
        payload_valid_i  = 1'b0;
        payload_i        = '0;
        on_off_i         = 2'b11;
        is_allocatable_i = 2'b11;

        // Reset behaviour
        tick(); #1;
        chk("rst.pkt_ready_in_reset", 32'(pkt_ready_o), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("rst.valid", 32'(valid_flit_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.pkt_ready", 32'(pkt_ready_o), 32'd1);
        chk("rst.payload_ready", 32'(payload_ready_o), 32'd0);

        // Single-flit packet: HEADTAIL at t+3
        pkt_dest_x_i = 4'd2; pkt_dest_y_i = 4'd1; pkt_len_i = 8'd1; pkt_valid_i = 1'b1; #1;
        chk("t2.pkt_ready", 32'(pkt_ready_o), 32'd1);
        tick(); pkt_valid_i = 1'b0; #1;
        chk("t2.t1_valid", 32'(valid_flit_o), 32'd0);
        chk("t2.t1_busy", 32'(busy_o), 32'd1);
        tick(); #1;
        chk("t2.t2_valid", 32'(valid_flit_o), 32'd0);
        tick(); #1;
        chk_flit("t2.headtail", HEADTAIL, 1'b0, 32'h2100_0000);
        tick(); #1;
        chk("t2.t4_valid", 32'(valid_flit_o), 32'd0);
        chk("t2.t4_busy", 32'(busy_o), 32'd0);

        // len=4 with on_off[0] dropped for 2 cycles after the first body
        do_reset();
        pkt_dest_x_i = 4'd3; pkt_dest_y_i = 4'd2; pkt_len_i = 8'd4; pkt_valid_i = 1'b1;
        tick(); pkt_valid_i = 1'b0; payload_valid_i = 1'b1; payload_i = 32'hAAAA_0001; #1;
        chk("t3.pr_alloc", 32'(payload_ready_o), 32'd0);
        tick(); #1;
        chk("t3.pr_head", 32'(payload_ready_o), 32'd0);
        tick(); #1;
        chk_flit("t3.head", HEAD, 1'b0, 32'h3200_0000);
        chk("t3.pr_body", 32'(payload_ready_o), 32'd1);
        tick(); payload_i = 32'hBBBB_0002; on_off_i = 2'b10; #1;
        chk_flit("t3.body_a", BODY, 1'b0, 32'hAAAA_0001);
        chk("t3.pr_off1", 32'(payload_ready_o), 32'd0);
        tick(); #1;
        chk("t3.valid_off1", 32'(valid_flit_o), 32'd0);
        chk("t3.pr_off2", 32'(payload_ready_o), 32'd0);
        tick(); on_off_i = 2'b11; #1;
        chk("t3.valid_off2", 32'(valid_flit_o), 32'd0);
        chk("t3.pr_on", 32'(payload_ready_o), 32'd1);
        tick(); payload_i = 32'hCCCC_0003; #1;
        chk_flit("t3.body_b", BODY, 1'b0, 32'hBBBB_0002);
        tick(); payload_valid_i = 1'b0; #1;
        chk_flit("t3.tail_c", TAIL, 1'b0, 32'hCCCC_0003);
        chk("t3.busy_after_tail", 32'(busy_o), 32'd0);
        tick(); #1;
        chk("t3.valid_after", 32'(valid_flit_o), 32'd0);

        // Back-to-back len=2 packets alternate VCs; then holdoff blocks VC0 reuse
        do_reset();
        pkt_dest_x_i = 4'd1; pkt_dest_y_i = 4'd1; pkt_len_i = 8'd2; pkt_valid_i = 1'b1;
        tick(); pkt_valid_i = 1'b0; payload_valid_i = 1'b1; payload_i = 32'h1111_0001;
        tick();
        tick(); pkt_dest_x_i = 4'd1; pkt_dest_y_i = 4'd2; pkt_valid_i = 1'b1; #1;
        chk_flit("t4.p1_head", HEAD, 1'b0, 32'h1100_0000);
        chk("t4.pkt_ready_busy", 32'(pkt_ready_o), 32'd0);
        tick(); payload_i = 32'h2222_0002; #1;
        chk_flit("t4.p1_tail", TAIL, 1'b0, 32'h1111_0001);
        chk("t4.pkt_ready_after_tail", 32'(pkt_ready_o), 32'd1);
        tick(); pkt_valid_i = 1'b0; #1;
        chk("t4.valid_t5", 32'(valid_flit_o), 32'd0);
        tick();
        tick(); #1;
        chk_flit("t4.p2_head", HEAD, 1'b1, 32'h1200_0000);
        tick();
        pkt_dest_x_i = 4'd0; pkt_dest_y_i = 4'd3; pkt_len_i = 8'd1; pkt_valid_i = 1'b1;
        is_allocatable_i = 2'b01; payload_valid_i = 1'b0; #1;
        chk_flit("t4.p2_tail", TAIL, 1'b1, 32'h2222_0002);
        tick(); pkt_valid_i = 1'b0;
        tick();
        tick(); pkt_dest_x_i = 4'd2; pkt_dest_y_i = 4'd2; pkt_valid_i = 1'b1; #1;
        chk_flit("t4.p3_headtail", HEADTAIL, 1'b0, 32'h0300_0000);
        tick(); pkt_valid_i = 1'b0; #1;
        chk("t4.hold_valid0", 32'(valid_flit_o), 32'd0);
        chk("t4.hold_busy", 32'(busy_o), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick(); #1;
            chk($sformatf("t4.hold_valid%0d", i), 32'(valid_flit_o), 32'd0);
        end
        tick(); #1;
        chk_flit("t4.p4_headtail", HEADTAIL, 1'b0, 32'h2200_0000);

        // No allocatable VC: wait in ALLOC, then grant VC1
        do_reset();
        is_allocatable_i = 2'b00;
        pkt_dest_x_i = 4'd1; pkt_dest_y_i = 4'd3; pkt_len_i = 8'd1; pkt_valid_i = 1'b1;
        tick(); pkt_valid_i = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick(); #1; end
            chk($sformatf("t5.stall_valid%0d", i), 32'(valid_flit_o), 32'd0);
            chk($sformatf("t5.stall_busy%0d", i), 32'(busy_o), 32'd1);
        end
        is_allocatable_i = 2'b10;
        tick(); #1;
        chk("t5.valid_head_cycle", 32'(valid_flit_o), 32'd0);
        tick(); #1;
        chk_flit("t5.headtail_vc1", HEADTAIL, 1'b1, 32'h1300_0000);

        // Reset during BODY of a len=5 packet
        do_reset();
        is_allocatable_i = 2'b11;
        pkt_dest_x_i = 4'd3; pkt_dest_y_i = 4'd3; pkt_len_i = 8'd5; pkt_valid_i = 1'b1;
        tick(); pkt_valid_i = 1'b0; payload_valid_i = 1'b1; payload_i = 32'h5555_0000;
        tick();
        tick(); #1;
        chk_flit("t6.head", HEAD, 1'b0, 32'h3300_0000);
        tick(); rst = 1'b1; #1;
        chk_flit("t6.body0", BODY, 1'b0, 32'h5555_0000);
        chk("t6.pr_in_reset", 32'(payload_ready_o), 32'd0);
        tick(); rst = 1'b0;
        pkt_dest_x_i = 4'd1; pkt_dest_y_i = 4'd0; pkt_len_i = 8'd2; pkt_valid_i = 1'b1; #1;
        chk("t6.valid_after_rst", 32'(valid_flit_o), 32'd0);
        chk("t6.busy_after_rst", 32'(busy_o), 32'd0);
        chk("t6.pkt_ready_after_rst", 32'(pkt_ready_o), 32'd1);
        tick(); pkt_valid_i = 1'b0; payload_i = 32'h6666_0001;
        tick();
        tick(); #1;
        chk_flit("t6.new_head", HEAD, 1'b0, 32'h1000_0000);
        tick(); #1;
        chk_flit("t6.new_tail", TAIL, 1'b0, 32'h6666_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/node_injector.md
Name: node_injector

Overview:
Node-side transmitter that drives a router's local input port over the router2router link, acting as the upstream end of that port.
- Accepts packet descriptors and a payload word stream from the processing element.
- Allocates a downstream VC using the per-VC is_allocatable indication.
- Serialises each packet into HEAD/BODY/TAIL (or HEADTAIL) flits, gated per flit by the router's per-VC on_off flow control.
- Sends one packet at a time.

Parameters:
- VC_NUM, 2, virtual channels on the link.
- PKT_LEN_W, 8, width of the packet length field in flits.
- REALLOC_HOLDOFF, 5, cycles after a tail during which that VC is ineligible for reallocation; equals the router pipeline depth.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_valid_i  in  1  descriptor valid
- pkt_ready_o  out  1  descriptor accepted when high together with pkt_valid_i
- pkt_dest_x_i  in  DEST_ADDR_SIZE_X  destination x
- pkt_dest_y_i  in  DEST_ADDR_SIZE_Y  destination y
- pkt_len_i  in  PKT_LEN_W  packet length in flits including head; 0 is treated as 1
- payload_valid_i  in  1  body/tail payload word available
- payload_i  in  FLIT_DATA_SIZE  body/tail payload word
- payload_ready_o  out  1  payload word consumed this cycle
- data_o  out  flit_t  flit to router local port
- valid_flit_o  out  1  data_o valid, one cycle per flit
- on_off_i  in  VC_NUM  per-VC permission to send; 1 = send allowed
- is_allocatable_i  in  VC_NUM  per-VC downstream idle, may take a new packet
- busy_o  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset (synchronous): state IDLE, valid_flit_o=0, data_o=0, payload_ready_o=0, busy_o=0, round-robin pointer=0, all holdoff counters=0. pkt_ready_o=0 during the reset cycle, then 1 in IDLE.
- data_o and valid_flit_o are registered. A flit decided in cycle t is visible in cycle t+1. valid_flit_o is low in every cycle without a new flit.
- IDLE:
  - pkt_ready_o=1.
  - On handshake: latch dest, latch remaining = max(pkt_len_i,1)-1, go to ALLOC.
- ALLOC:
  - eligible[v] = is_allocatable_i[v] & (holdoff[v]==0).
  - Round-robin grant starting at the pointer; latch the granted VC; pointer = grant+1 mod VC_NUM; go to HEAD.
  - No eligible VC: stay in ALLOC with no output.
- HEAD:
  - If on_off_i[vc]=1, emit the head flit:
    - flit_label = HEADTAIL if remaining==0, else HEAD.
    - vc_id = vc.
    - head_data.x_dest / y_dest = latched destination; other head fields 0.
  - If remaining==0: load holdoff[vc]=REALLOC_HOLDOFF, go to IDLE. Otherwise go to BODY.
  - If on_off_i[vc]=0: stall, no flit.
- BODY:
  - payload_ready_o = on_off_i[vc] & payload_valid_i (combinational, only in BODY).
  - When it is high, emit a flit with flit_label = TAIL if remaining==1 else BODY, vc_id = vc, bt_pl = payload_i; then remaining--.
  - On TAIL: load holdoff[vc], go to IDLE.
  - No flit when on_off_i[vc]=0 or payload_valid_i=0.
- Holdoff counters decrement by 1 per cycle to 0, independently of state.
- on_off_i and is_allocatable_i are sampled in the decision cycle only; the injector keeps no credit count.
- Best-case latency: descriptor handshake in cycle t gives the head flit visible in cycle t+3. Each following flit can be visible every cycle.
- A new descriptor is accepted no earlier than the cycle after the tail decision. Payload words are never consumed in IDLE, ALLOC or HEAD.
- Reset mid-packet: the packet is abandoned, valid_flit_o is 0 in the cycle after reset, and no tail is generated.

Decomposition:
- noc_params (shared package) holds: flit_t, flit_label_t (HEAD, BODY, TAIL, HEADTAIL), DEST_ADDR_SIZE_X/Y, FLIT_DATA_SIZE.
- New package entry: injector_state_t enum {IDLE, ALLOC, HEAD, BODY}.
- Sub-module: rr_vc_arbiter (VC_NUM request vector, pointer, one-hot grant), kept separate for reuse.

Test Plan:
- Reset → in the cycle after rst drops: valid_flit_o=0, busy_o=0, pkt_ready_o=1, payload_ready_o=0.
- Descriptor (x=2, y=1, len=1), is_allocatable=2'b11, on_off=2'b11 → single HEADTAIL flit, vc_id=0, dest (2,1), valid high exactly in cycle t+3.
- len=4, payload words A,B,C, on_off[0] dropped for 2 cycles after the first body → flits HEAD, BODY(A), BODY(B), TAIL(C) in order; no valid and no payload_ready while off.
- Two back-to-back len=2 packets, both VCs allocatable → first packet on VC0, second on VC1. A third packet within 5 cycles of VC0's tail, with only is_allocatable[0]=1, waits in ALLOC until holdoff expires.
- is_allocatable=2'b00 after handshake → stays in ALLOC with no flits and busy_o=1. Raising is_allocatable[1] → head on vc_id=1 two cycles later.
- rst asserted during BODY of a len=5 packet → valid_flit_o=0 in the next cycle, state IDLE, a new packet starts with a HEAD flit.
